debug_seg7_driver: RTL and testbench

//  Board-level consumer of the core's 10-bit debug bus (low bits of LO).

---
 rtl/debug_seg7_driver_pkg.sv | 47 ++++
 rtl/debug_seg7_driver_if.sv | 18 +
 rtl/debug_seg7_driver_bin2bcd_seq.sv | 76 +++++++
 rtl/debug_seg7_driver.sv | 104 ++++++++++
 tb/tb_debug_seg7_driver.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_seg7_driver_pkg.sv
// Shared definitions for the debug-bus seven-segment display driver.
// Holds the debug bus width, the active-low segment codes ({g,f,e,d,c,b,a}),
// the converter FSM state encoding and the BCD-to-segment decode function.
package debug_seg7_driver_pkg;

  localparam int DEBUG_W = 10;
  localparam int BCD_W   = 16;
  localparam int SR_W    = BCD_W + DEBUG_W;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;

  typedef enum logic [1:0] {
    S7_IDLE  = 2'd0,
    S7_SHIFT = 2'd1,
    S7_LOAD  = 2'd2
  } s7_state_e;

  // Codes 10..15 never come out of the converter; show them as blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/debug_seg7_driver_if.sv
// Board-side bundle of the display driver.
//   debug_i : 10-bit unsigned value to show
//   seg_o   : segments {g,f,e,d,c,b,a}, active-low
//   an_o    : digit enables, active-low, an_o[0] = ones digit
//   busy_o  : high while a conversion is running
// slave is the driver side, master the side that supplies debug_i.
interface debug_seg7_driver_if;
  import debug_seg7_driver_pkg::*;

  logic [DEBUG_W-1:0] debug_i;
  logic [6:0]         seg_o;
  logic [3:0]         an_o;
  logic               busy_o;

  modport master (output debug_i, input seg_o, an_o, busy_o);
  modport slave  (input debug_i, output seg_o, an_o, busy_o);

endinterface

// File: rtl/debug_seg7_driver_bin2bcd_seq.sv
// Sequential double-dabble converter, 10-bit binary to 4 BCD digits.
//   clk, rst : clock, synchronous active-high reset (returns FSM to IDLE)
//   start    : accepted only in IDLE; latches bin and begins conversion
//   bin      : binary input
//   done     : one-cycle pulse while the result on bcd is final
//   bcd      : {thousands, hundreds, tens, ones}
// Takes 1 load cycle, 10 shift cycles and 1 done cycle.
module debug_seg7_driver_bin2bcd_seq
  import debug_seg7_driver_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DEBUG_W-1:0] bin,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  s7_state_e       state_q, state_d;
  logic [3:0]      iter_q, iter_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] adj;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    sr_d    = sr_q;
    done    = 1'b0;
    adj     = sr_q[SR_W-1:DEBUG_W];
    // Add 3 to any nibble >= 5 so the following shift carries into the next digit.
    for (int k = 0; k < 4; k++) begin
      if (sr_q[DEBUG_W + 4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = sr_q[DEBUG_W + 4*k +: 4] + 4'd3;
      end
    end
    case (state_q)
      S7_IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin};
          iter_d  = 4'd0;
          state_d = S7_SHIFT;
        end
      end
      S7_SHIFT: begin
        sr_d   = ({adj, sr_q[DEBUG_W-1:0]} << 1);
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'(DEBUG_W - 1)) begin
          state_d = S7_LOAD;
        end
      end
      S7_LOAD: begin
        done    = 1'b1;
        state_d = S7_IDLE;
      end
      default: state_d = S7_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S7_IDLE;
      iter_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Shift register is pure datapath; it is always reloaded before use.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign bcd = sr_q[SR_W-1:DEBUG_W];

endmodule

// File: rtl/debug_seg7_driver.sv
// Debug-bus display driver: shows the 10-bit debug value as up to four decimal
// digits on a time-multiplexed common-anode seven-segment display.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : slave side of debug_seg7_driver_if (debug_i in; seg_o, an_o, busy_o out)
// Parameters: REFRESH_DIV cycles per lit digit (>= 2); BLANK_LZ blanks leading zeros.
// A change on debug_i is converted in the background and shown 12 cycles later;
// changes arriving while busy are picked up once the converter is idle again.
module debug_seg7_driver
  import debug_seg7_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic                clk,
  input logic                rst,
  debug_seg7_driver_if.slave bus
);

  localparam int                DIV_W   = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

  logic [DEBUG_W-1:0] last_val_q, last_val_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         idx_q, idx_d;
  logic               scan_en_q, scan_en_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               start, done, wrap;
  logic [BCD_W-1:0]   bcd;
  logic [3:0]         blank;
  logic [3:0]         digit;

  debug_seg7_driver_bin2bcd_seq u_bin2bcd_seq (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bus.debug_i),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    // Change detect: only while the converter is idle, so the last stable value wins.
    start      = !busy_q && (bus.debug_i != last_val_q);
    last_val_d = start ? bus.debug_i : last_val_q;
    busy_d     = busy_q;
    if (start) begin
      busy_d = 1'b1;
    end else if (done) begin
      busy_d = 1'b0;
    end
    digits_d = done ? bcd : digits_q;

    // Scan: the first wrap only enables the outputs on digit 0; later wraps advance.
    wrap      = (div_q == DIV_MAX);
    div_d     = wrap ? '0 : div_q + 1'b1;
    scan_en_d = scan_en_q | wrap;
    idx_d     = (wrap && scan_en_q) ? idx_q + 2'd1 : idx_q;

    // Leading-zero blanking cascades down from the thousands digit; ones never blanks.
    blank[3] = BLANK_LZ && (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
    blank[0] = 1'b0;

    digit = digits_q[4*idx_q +: 4];
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    if (scan_en_q) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank[idx_q] ? SEG_BLANK : seg_decode(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val_q <= '0;
      busy_q     <= 1'b0;
      digits_q   <= '0;
      div_q      <= '0;
      idx_q      <= 2'd0;
      scan_en_q  <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
    end else begin
      last_val_q <= last_val_d;
      busy_q     <= busy_d;
      digits_q   <= digits_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      scan_en_q  <= scan_en_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg_o  = seg_q;
  assign bus.an_o   = an_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_debug_seg7_driver.sv
`timescale 1ns/1ps
module tb_debug_seg7_driver;
  import debug_seg7_driver_pkg::*;

  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_seg7_driver_if bus();
  debug_seg7_driver_if bus_nb();
  assign bus_nb.debug_i = bus.debug_i;

  debug_seg7_driver #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  debug_seg7_driver #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // segs packs the expected per-digit codes as {d3,d2,d1,d0}.
  typedef struct packed {
    logic [9:0]  val;
    logic [27:0] segs;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal split with leading-zero blanking: digit k>0 is blank when v < 10^k.
  function automatic logic [27:0] ref_segs(input int v);
    logic [27:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[7*k +: 7] = (k > 0 && v < p) ? 7'h7F : ref_seg((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic       prev_busy = 1'b0;
  int         busy_cnt  = 0;
  bit         capturing = 1'b0;
  bit         cap_first = 1'b0;
  int         cap_cnt   = 0;
  logic [3:0] seen      = 4'h0;
  logic [6:0] cap_seg [4];
  exp_t       cur;
  logic [3:0] an_prev   = 4'hF;
  int         an_run    = 0;

  task automatic finalize();
    int nseen;
    nseen = 0;
    for (int k = 0; k < 4; k++) begin
      if (seen[k]) begin
        nseen++;
        check($sformatf("digit%0d_val%0d", k, cur.val), 32'(cap_seg[k]), 32'(cur.segs[7*k +: 7]));
      end
    end
    check($sformatf("digits_seen_val%0d", cur.val), (nseen >= 3) ? 32'd1 : 32'd0, 32'd1);
    capturing = 1'b0;
  endtask

  initial begin : monitor
    logic [3:0] one_hot;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        busy_cnt  = 0;
        capturing = 1'b0;
        an_prev   = 4'hF;
        an_run    = 0;
      end else begin
        if (bus.an_o != an_prev) begin
          if (an_prev != 4'hF) begin
            check("scan_order", 32'(bus.an_o), 32'({an_prev[2:0], an_prev[3]}));
            check("scan_dwell", an_run, RDIV);
          end
          an_prev = bus.an_o;
          an_run  = 1;
        end else begin
          an_run++;
        end

        if (capturing && !cap_first) begin
          for (int k = 0; k < 4; k++) begin
            one_hot = ~(4'b0001 << k);
            if (bus.an_o == one_hot) begin
              cap_seg[k] = bus.seg_o;
              seen[k]    = 1'b1;
            end
          end
          cap_cnt++;
        end
        cap_first = 1'b0;
        if (capturing && (cap_cnt >= 4*RDIV || (prev_busy && !bus.busy_o))) finalize();

        if (bus.busy_o) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
        if (prev_busy && !bus.busy_o) begin
          check("busy_len", busy_cnt, 11);
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_commit actual=commit required=none");
          end else begin
            cur       = sb_q.pop_front();
            capturing = 1'b1;
            cap_first = 1'b1;
            cap_cnt   = 0;
            seen      = 4'h0;
          end
        end
        prev_busy = bus.busy_o;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply(input int v);
    @(posedge clk);
    #1 bus.debug_i = 10'(v);
  endtask

  task automatic rise_check(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.busy_o && n < 5);
    check(name, n, 2);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = (sb_q.size() == 0) && !bus.busy_o;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    repeat (4*RDIV + 2) @(negedge clk);
  endtask

  task automatic expect_digit(input bit nb, input logic [3:0] an, input logic [6:0] seg,
                              input string name);
    bit hit;
    logic [3:0] a;
    logic [6:0] s;
    hit = 1'b0;
    s   = 7'h7F;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      a   = nb ? bus_nb.an_o  : bus.an_o;
      s   = nb ? bus_nb.seg_o : bus.seg_o;
      hit = (a == an);
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout actual=no_an required=%0h", name, an);
    end else begin
      check(name, 32'(s), 32'(seg));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit hit;
    bus.debug_i = '0;
    rst = 1'b1;

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seg", 32'(bus.seg_o), 32'h7F);
    check("rst_an", 32'(bus.an_o), 32'hF);
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk);
      hit = (bus.an_o != 4'hF);
    end
    check("first_an", 32'(bus.an_o), 32'hE);
    check("first_seg", 32'(bus.seg_o), 32'h40);
    expect_digit(1'b0, 4'hD, 7'h7F, "zero_d1_blank");
    expect_digit(1'b0, 4'hB, 7'h7F, "zero_d2_blank");
    expect_digit(1'b0, 4'h7, 7'h7F, "zero_d3_blank");

    // 2: full-scale value
    sb_q.push_back('{val: 10'd1023, segs: {7'h79, 7'h40, 7'h24, 7'h30}});
    apply(1023);
    rise_check("rise_1023");
    wait_idle("w1023");

    // 3: single digit, with and without blanking
    sb_q.push_back('{val: 10'd5, segs: {7'h7F, 7'h7F, 7'h7F, 7'h12}});
    apply(5);
    rise_check("rise_5");
    wait_idle("w5");
    expect_digit(1'b1, 4'hE, 7'h12, "nb_d0");
    expect_digit(1'b1, 4'hD, 7'h40, "nb_d1");
    expect_digit(1'b1, 4'hB, 7'h40, "nb_d2");
    expect_digit(1'b1, 4'h7, 7'h40, "nb_d3");

    // 4: change while busy
    sb_q.push_back('{val: 10'd100, segs: {7'h7F, 7'h79, 7'h40, 7'h40}});
    sb_q.push_back('{val: 10'd200, segs: {7'h7F, 7'h24, 7'h40, 7'h40}});
    apply(100);
    rise_check("rise_100");
    repeat (3) @(posedge clk);
    #1 bus.debug_i = 10'd200;
    wait_idle("w200");

    // 5: reset mid-conversion
    apply(777);
    rise_check("rise_777a");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy_o), 32'h0);
    check("midrst_seg", 32'(bus.seg_o), 32'h7F);
    check("midrst_an", 32'(bus.an_o), 32'hF);
    sb_q.push_back('{val: 10'd777, segs: {7'h7F, 7'h78, 7'h78, 7'h78}});
    @(posedge clk);
    #1 rst = 1'b0;
    rise_check("rise_777b");
    wait_idle("w777");

    // 6: sweep
    for (int v = 0; v < 1024; v++) begin
      sb_q.push_back('{val: 10'(v), segs: ref_segs(v)});
      apply(v);
      rise_check($sformatf("rise_sweep%0d", v));
      wait_idle($sformatf("wsweep%0d", v));
    end

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
